// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Sequential instruction fetcher over a small on-chip program memory of
//   17-bit words. A run begins at start_addr and issues one word per
//   unstalled cycle to downstream decode. It stops when the word at pc equals
//   HALT_WORD. The program memory is loaded through the prog_* port whenever
//   the unit is not fetching.
//
// Parameters:
//   DEPTH      number of 17-bit program words
//   HALT_WORD  encoding that terminates a run (never issued downstream)
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   begin a run at start_addr (honoured in IDLE/HALT)
//   start_addr   in   7   first pc of a run (reduced modulo DEPTH)
//   stall        in   1   downstream not ready; freezes the fetch state
//   prog_we      in   1   program-load write enable (honoured in IDLE/HALT)
//   prog_addr    in   7   program-load address (reduced modulo DEPTH)
//   prog_data    in  17   program-load word
//   instruction  out 17   registered instruction {op,WA,RA1,RA2}
//   instr_valid  out  1   instruction carries an issued word
//   pc           out  7   address of the next word to fetch
//   halted       out  1   run ended on HALT_WORD
//   busy         out  1   run in progress
//   instr_count  out 16   words issued since the last start (saturating)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          DEPTH     = 128,
  parameter logic [16:0] HALT_WORD = 17'h1FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  start_addr,
  input  logic        stall,
  input  logic        prog_we,
  input  logic [6:0]  prog_addr,
  input  logic [16:0] prog_data,
  output logic [16:0] instruction,
  output logic        instr_valid,
  output logic [6:0]  pc,
  output logic        halted,
  output logic        busy,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Reduce an externally supplied address into the implemented range.
  function automatic logic [6:0] wrap_addr(input logic [6:0] a);
    wrap_addr = 7'(32'(a) % DEPTH);
  endfunction

  // Saturating increment for the issue counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  logic [16:0] r_mem [DEPTH];

  state_t      r_state;
  logic        r_primed;      // first FETCH cycle is a pipeline fill slot
  logic [6:0]  r_pc;
  logic [16:0] r_instr;
  logic        r_valid;
  logic        r_halted;
  logic        r_busy;
  logic [15:0] r_count;

  logic [16:0] w_rd_word;
  logic [6:0]  w_pc_next;
  logic        w_load_ok;

  assign w_rd_word = r_mem[r_pc];
  assign w_pc_next = (r_pc == 7'(DEPTH - 1)) ? 7'd0 : (r_pc + 7'd1);
  // Loads are locked out during a run so the stream being issued is stable.
  assign w_load_ok = prog_we && (r_state != ST_FETCH);

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[wrap_addr(prog_addr)] <= prog_data;
    end else begin
      r_mem[wrap_addr(prog_addr)] <= r_mem[wrap_addr(prog_addr)];
    end
  end

  // Fetch control FSM with all downstream outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_primed <= 1'b0;
      r_pc     <= 7'd0;
      r_instr  <= 17'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            r_state  <= ST_FETCH;
            r_primed <= 1'b0;
            r_pc     <= wrap_addr(start_addr);
            r_count  <= 16'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_state <= r_state;
          end
        end
        ST_FETCH: begin
          if (stall) begin
            // Everything holds; a presented word stays presented.
            r_state <= r_state;
          end else if (!r_primed) begin
            // Fill slot: gives the first issue a two-edge latency from start
            // and lets a same-edge load of start_addr be read back.
            r_primed <= 1'b1;
          end else if (w_rd_word == HALT_WORD) begin
            // pc stays on the halt word; last instruction stays visible.
            r_state  <= ST_HALT;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_instr <= w_rd_word;
            r_valid <= 1'b1;
            r_pc    <= w_pc_next;
            r_count <= sat_inc(r_count);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_primed <= 1'b0;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign busy        = r_busy;
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. The reference model predicts each
// run as a list of words (walk memory from start_addr until HALT_WORD), then
// tracks how many of those words have been issued; every visible output is
// derived from that issue index.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [16:0] HALT = 17'h1FFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  start_addr;
  logic        stall;
  logic        prog_we;
  logic [6:0]  prog_addr;
  logic [16:0] prog_data;
  logic [16:0] instruction;
  logic        instr_valid;
  logic [6:0]  pc;
  logic        halted;
  logic        busy;
  logic [15:0] instr_count;

  instr_fetch_unit #(.DEPTH(128), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .busy(busy),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [16:0] m_mem [128];
  logic [16:0] m_list [$];
  int          m_phase;   // 0 = fill slot pending, 1 = issuing, 2 = halted
  int          m_n;       // words issued this run
  int          m_start;
  logic [16:0] m_last;    // last issued word (survives runs, cleared by reset)

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".instr"}, 32'(instruction), 32'(m_last));
    chk({tag, ".valid"}, 32'(instr_valid), 32'((m_phase == 1) && (m_n > 0)));
    chk({tag, ".pc"}, 32'(pc), 32'((m_start + m_n) % 128));
    chk({tag, ".count"}, 32'(instr_count), 32'(m_n));
    chk({tag, ".busy"}, 32'(busy), 32'(m_phase < 2));
    chk({tag, ".halted"}, 32'(halted), 32'(m_phase == 2));
  endtask

  task automatic load_word(input int a, input logic [16:0] d);
    prog_we   = 1'b1;
    prog_addr = 7'(a);
    prog_data = d;
    m_mem[a]  = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  function automatic logic [16:0] rand_word();
    logic [16:0] w;
    w = 17'($urandom);
    if (w == HALT) w = 17'h00000;
    return w;
  endfunction

  // Build the expected issue list from the model memory.
  task automatic build_list(input int sa);
    int p;
    m_list.delete();
    p = sa;
    for (int k = 0; k < 130; k++) begin
      if (m_mem[p] == HALT) break;
      m_list.push_back(m_mem[p]);
      p = (p + 1) % 128;
    end
  endtask

  // One run: start (optionally with a same-edge load at start_addr), then
  // clock until halt with stall from mask and/or random percentage.
  task automatic run(input int sa, input int pct, input logic [63:0] mask,
                     input bit wr_mid, input bit wr_start, input logic [16:0] wr_data,
                     input string tag);
    logic s;
    start      = 1'b1;
    start_addr = 7'(sa);
    if (wr_start) begin
      prog_we   = 1'b1;
      prog_addr = 7'(sa);
      prog_data = wr_data;
      m_mem[sa] = wr_data;
    end
    build_list(sa);
    @(posedge clk);
    #1;
    start   = 1'b0;
    prog_we = 1'b0;
    m_phase = 0;
    m_n     = 0;
    m_start = sa;
    check_all({tag, ".start"});
    for (int c = 0; c < 600 && m_phase != 2; c++) begin
      s = (c < 64) ? mask[c] : 1'b0;
      if (($urandom % 100) < pct) s = 1'b1;
      stall = s;
      // Load attempted mid-run must be ignored by the memory.
      if (wr_mid && c == 1) begin
        prog_we   = 1'b1;
        prog_addr = 7'd5;
        prog_data = 17'h0ABCD;
      end
      @(posedge clk);
      #1;
      prog_we = 1'b0;
      if (!s) begin
        if (m_phase == 0) m_phase = 1;
        else if (m_n == m_list.size()) m_phase = 2;
        else begin
          m_last = m_list[m_n];
          m_n++;
        end
      end
      check_all({tag, ".run"});
    end
    if (m_phase != 2) chk({tag, ".timeout"}, 32'd0, 32'd1);
    // HALT is insensitive to stall.
    for (int c = 0; c < 3; c++) begin
      stall = 1'($urandom);
      @(posedge clk);
      #1;
      check_all({tag, ".halt"});
    end
    stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = 7'd0; stall = 1'b0;
    prog_we = 1'b0; prog_addr = 7'd0; prog_data = 17'd0;
    m_phase = 2; m_n = 0; m_start = 0; m_last = 17'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: idle, not halted, everything zero.
    chk("rst.instr", 32'(instruction), 32'd0);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.count", 32'(instr_count), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    rst_n = 1'b1;

    // Known background for the whole memory.
    for (int a = 0; a < 128; a++) load_word(a, rand_word());

    // Basic three-word program.
    load_word(0, 17'h00443);
    load_word(1, 17'h08C85);
    load_word(2, HALT);
    run(0, 0, 64'd0, 1'b0, 1'b0, 17'd0, "basic");
    chk("basic.final_pc", 32'(pc), 32'd2);
    chk("basic.final_cnt", 32'(instr_count), 32'd2);

    // Stall for three cycles while the first word is presented.
    run(0, 0, 64'h1C, 1'b0, 1'b0, 17'd0, "stall3");
    chk("stall3.final_cnt", 32'(instr_count), 32'd2);

    // Wrap from the top address back to zero.
    load_word(127, 17'h10001);
    load_word(0, HALT);
    run(127, 0, 64'd0, 1'b0, 1'b0, 17'd0, "wrap");
    chk("wrap.final_pc", 32'(pc), 32'd0);
    chk("wrap.last", 32'(instruction), 32'h10001);

    // Mid-run load of mem[5] is ignored; a later run reads the old word.
    for (int a = 1; a < 10; a++) load_word(a, rand_word());
    if (m_mem[5] == 17'h0ABCD) load_word(5, 17'h00005);
    load_word(10, HALT);
    run(1, 0, 64'd0, 1'b1, 1'b0, 17'd0, "wrmid");
    run(1, 0, 64'd0, 1'b0, 1'b0, 17'd0, "wrmid_rb");

    // Restart from HALT at address 3; count clears.
    run(3, 20, 64'd0, 1'b0, 1'b0, 17'd0, "restart3");

    // Same-edge load of start_addr and start: first fetch sees new word.
    run(4, 0, 64'd0, 1'b0, 1'b1, 17'h01234, "wrstart");

    // Reset while a word is valid: outputs clear without a clock edge.
    start = 1'b1; start_addr = 7'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid.valid_before", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.instr", 32'(instruction), 32'd0);
    chk("mid.valid", 32'(instr_valid), 32'd0);
    chk("mid.pc", 32'(pc), 32'd0);
    chk("mid.count", 32'(instr_count), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 17'd0; m_phase = 2; m_n = 0; m_start = 0;
    // No fetch without a start after reset.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst.busy", 32'(busy), 32'd0);
      chk("post_rst.valid", 32'(instr_valid), 32'd0);
    end
    run(1, 0, 64'd0, 1'b0, 1'b0, 17'd0, "rerun");

    // Randomized programs, starts and stall patterns (including wraps).
    for (int r = 0; r < 20; r++) begin
      int sa;
      int len;
      sa  = $urandom_range(0, 127);
      len = $urandom_range(0, 20);
      for (int k = 0; k < len; k++) load_word((sa + k) % 128, rand_word());
      load_word((sa + len) % 128, HALT);
      run(sa, $urandom_range(0, 50), 64'd0, 1'b0, 1'b0, 17'd0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
